// File: rtl/nano_dbg_spi_pkg.sv
// rtl/nano_dbg_spi_pkg.sv - shared FSM state type and NanoController debug-port opcodes
package nano_dbg_spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} t_spi_state;

  localparam logic [7:0] CMD_CTRL    = 8'd0;
  localparam logic [7:0] CMD_CLKEN   = 8'd32;
  localparam logic [7:0] CMD_IMEM    = 8'd48;
  localparam logic [7:0] CMD_CLUT    = 8'd96;
  localparam logic [7:0] CMD_SCHG_LO = 8'd112;
  localparam logic [7:0] CMD_SCHG_HI = 8'd113;
  localparam logic [7:0] CMD_RD_CTRL = 8'd144;

endpackage

// File: rtl/nano_dbg_spi_master_clkdiv.sv
// rtl/nano_dbg_spi_master_clkdiv.sv - SCLK half-period divider, one tick every H cycles while running
module nano_dbg_spi_clkdiv #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [DIV_W-1:0] half_period,
  output logic             tick
);

  logic [DIV_W-1:0] reload_q, reload_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  // half_period arrives already clamped to >= 1, so H-1 never wraps
  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    if (start) begin
      reload_d = half_period - DIV_W'(1);
      cnt_d    = half_period - DIV_W'(1);
    end else if (run) begin
      cnt_d = (cnt_q == '0) ? reload_q : cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == '0);

endmodule

// File: rtl/nano_dbg_spi_master.sv
// rtl/nano_dbg_spi_master.sv - SPI master for the NanoController debug port, one frame per request
module nano_dbg_spi_master
  import nano_dbg_spi_pkg::*;
#(
  parameter int MAX_DATA = 4,
  parameter int DIV_W    = 8,
  parameter int GAP_CYC  = 4,
  parameter int LEN_W    = $clog2(MAX_DATA + 1)
) (
  input  logic                  i_nano_clk,
  input  logic                  i_nano_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [7:0]            i_cmd_byte,
  input  logic                  i_cmd_is_read,
  input  logic [LEN_W-1:0]      i_cmd_len,
  input  logic [8*MAX_DATA-1:0] i_wr_data,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic [DIV_W-1:0]      i_half_period,
  input  logic                  i_abort,
  output logic                  o_rsp_valid,
  output logic [8*MAX_DATA-1:0] o_rdata,
  output logic                  o_busy,
  output logic                  o_dbg_spi_en_n,
  output logic                  o_dbg_spi_sclk,
  output logic                  o_dbg_spi_mosi,
  input  logic                  i_dbg_spi_miso
);

  localparam int FRAME_W = 8 * (MAX_DATA + 1);
  localparam int EDGE_W  = $clog2(2 * FRAME_W);
  localparam int BIT_W   = EDGE_W - 1;
  localparam int RX_IW   = $clog2(8 * MAX_DATA);
  localparam int GAP_W   = $clog2(GAP_CYC + 1);

  t_spi_state            state_q, state_d;
  logic                  is_read_q, is_read_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic [FRAME_W-1:0]    tx_q, tx_d;
  logic [8*MAX_DATA-1:0] rx_q, rx_d;
  logic [8*MAX_DATA-1:0] rdata_q, rdata_d;
  logic                  en_n_q, en_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [GAP_W-1:0]      gap_q, gap_d;

  logic                  start, run, tick, sample;
  logic [DIV_W-1:0]      half_eff;
  logic [LEN_W-1:0]      len_clamped;
  logic [FRAME_W-1:0]    tx_load;
  logic [EDGE_W-1:0]     last_edge;
  logic [BIT_W-1:0]      bit_idx;
  logic [RX_IW-1:0]      rx_idx;

  assign start       = (state_q == IDLE) && i_cmd_valid;
  assign run         = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign half_eff    = (i_half_period == '0) ? DIV_W'(1) : i_half_period;
  assign len_clamped = (i_cmd_len > LEN_W'(MAX_DATA)) ? LEN_W'(MAX_DATA) : i_cmd_len;
  assign last_edge   = EDGE_W'(16 * (int'(len_q) + 1) - 1);
  assign bit_idx     = edge_q[EDGE_W-1:1];
  // Data bit d lands at byte d/8, bit 7-(d%8): flipping the low three bits does that
  assign rx_idx      = RX_IW'(bit_idx - BIT_W'(8)) ^ RX_IW'(7);
  assign sample      = ~edge_q[0] ^ cpha_q;

  // Command first, then data byte 0..MAX_DATA-1; read frames shift zeros after the command
  always_comb begin
    tx_load = '0;
    tx_load[FRAME_W-1 -: 8] = i_cmd_byte;
    for (int k = 0; k < MAX_DATA; k++) begin
      tx_load[8*(MAX_DATA-1-k) +: 8] = i_cmd_is_read ? 8'h00 : i_wr_data[8*k +: 8];
    end
  end

  nano_dbg_spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk         (i_nano_clk),
    .rst_n       (i_nano_rst_n),
    .start       (start),
    .run         (run),
    .half_period (half_eff),
    .tick        (tick)
  );

  always_comb begin
    state_d     = state_q;
    is_read_d   = is_read_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    len_d       = len_q;
    edge_d      = edge_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    en_n_d      = en_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    gap_d       = gap_q;

    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          state_d   = SETUP;
          is_read_d = i_cmd_is_read;
          cpol_d    = i_cpol;
          cpha_d    = i_cpha;
          len_d     = len_clamped;
          edge_d    = '0;
          rx_d      = '0;
          en_n_d    = 1'b0;
          sclk_d    = i_cpol;
          mosi_d    = i_cpha ? 1'b0 : i_cmd_byte[7];
          tx_d      = i_cpha ? tx_load : (tx_load << 1);
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (sample) begin
            if (is_read_q && (bit_idx >= BIT_W'(8))) rx_d[rx_idx] = i_dbg_spi_miso;
          end else begin
            mosi_d = (edge_q == last_edge) ? 1'b0 : tx_q[FRAME_W-1];
            tx_d   = tx_q << 1;
          end
          if (edge_q == last_edge) state_d = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d     = GAP;
          en_n_d      = 1'b1;
          mosi_d      = 1'b0;
          rsp_valid_d = 1'b1;
          gap_d       = GAP_W'(GAP_CYC - 1);
          if (is_read_q) rdata_d = rx_q;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides a completion landing in the same cycle
    if (i_abort && run) begin
      state_d     = GAP;
      en_n_d      = 1'b1;
      sclk_d      = cpol_q;
      mosi_d      = 1'b0;
      rsp_valid_d = 1'b0;
      rdata_d     = rdata_q;
      gap_d       = GAP_W'(GAP_CYC - 1);
    end
  end

  always_ff @(posedge i_nano_clk) begin
    if (!i_nano_rst_n) begin
      state_q     <= IDLE;
      is_read_q   <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      len_q       <= '0;
      edge_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      en_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      is_read_q   <= is_read_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      len_q       <= len_d;
      edge_q      <= edge_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      en_n_q      <= en_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      gap_q       <= gap_d;
    end
  end

  assign o_cmd_ready    = (state_q == IDLE);
  assign o_busy         = (state_q != IDLE);
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rdata        = rdata_q;
  assign o_dbg_spi_en_n = en_n_q;
  assign o_dbg_spi_sclk = sclk_q;
  assign o_dbg_spi_mosi = mosi_q;

endmodule

// File: tb/tb_nano_dbg_spi_master.sv
// tb/tb_nano_dbg_spi_master.sv - scoreboard bench for nano_dbg_spi_master with an SPI slave model
module tb_nano_dbg_spi_master;
  import nano_dbg_spi_pkg::*;

  localparam int MAXD = 4;
  localparam int GAPC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_byte = '0;
  logic        cmd_is_read = 1'b0;
  logic [2:0]  cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [7:0]  half = '0;
  logic        abort = 1'b0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        busy, en_n, sclk, mosi, miso;

  int total = 0;
  int bad = 0;

  logic        cur_cpol = 1'b0;
  logic        cur_cpha = 1'b0;
  logic [39:0] slave_tx = '0;
  int          nsamp = 0;
  int          low_cnt = 0;
  int          rsp_cnt = 0;
  int          sclk_edges = 0;
  logic [7:0]  acc = '0;
  logic        sclk_prev = 1'b0;
  logic        en_prev = 1'b1;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] rdata_model = '0;

  always #5 clk = ~clk;

  nano_dbg_spi_master #(.MAX_DATA(MAXD), .DIV_W(8), .GAP_CYC(GAPC)) dut (
    .i_nano_clk     (clk),
    .i_nano_rst_n   (rst_n),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_byte     (cmd_byte),
    .i_cmd_is_read  (cmd_is_read),
    .i_cmd_len      (cmd_len),
    .i_wr_data      (wr_data),
    .i_cpol         (cpol),
    .i_cpha         (cpha),
    .i_half_period  (half),
    .i_abort        (abort),
    .o_rsp_valid    (rsp_valid),
    .o_rdata        (rdata),
    .o_busy         (busy),
    .o_dbg_spi_en_n (en_n),
    .o_dbg_spi_sclk (sclk),
    .o_dbg_spi_mosi (mosi),
    .i_dbg_spi_miso (miso)
  );

  assign miso = (nsamp < 40) ? slave_tx[39 - nsamp] : 1'b0;

  // Slave model: samples MOSI on its mode's sample edge, presents the next MISO bit afterwards
  always @(negedge clk) begin
    if (en_n) begin
      nsamp = 0;
      acc   = '0;
    end else if (!en_prev && (sclk !== sclk_prev)) begin
      sclk_edges++;
      if ((sclk != cur_cpol) ^ cur_cpha) begin
        acc = {acc[6:0], mosi};
        nsamp++;
        if (nsamp % 8 == 0) got_q.push_back(acc);
      end
    end
    if (!en_n) low_cnt++;
    if (rsp_valid) rsp_cnt++;
    sclk_prev = sclk;
    en_prev   = en_n;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [7:0] c, input logic rd, input int l,
                              input logic [31:0] w, input logic [39:0] stx);
    int n;
    n = (l > MAXD) ? MAXD : l;
    exp_q.push_back(c);
    for (int k = 0; k < n; k++) exp_q.push_back(rd ? 8'h00 : w[8*k +: 8]);
    if (rd) begin
      rdata_model = '0;
      for (int k = 0; k < n; k++) rdata_model[8*k +: 8] = stx[31 - 8*k -: 8];
    end
  endtask

  task automatic start_frame(input logic [7:0] c, input logic rd, input logic [2:0] l,
                             input logic [31:0] w, input logic pl, input logic ph,
                             input logic [7:0] h, input logic [39:0] stx);
    int waitc;
    waitc = 0;
    while (cmd_ready !== 1'b1 && waitc < 200) begin
      step();
      waitc++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait got=%0b exp=1", cmd_ready);
    end
    cur_cpol = pl;
    cur_cpha = ph;
    slave_tx = stx;
    cmd_byte = c;
    cmd_is_read = rd;
    cmd_len = l;
    wr_data = w;
    cpol = pl;
    cpha = ph;
    half = h;
    low_cnt = 0;
    rsp_cnt = 0;
    sclk_edges = 0;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    total++;
    if (en_n !== 1'b0 || sclk !== pl) begin
      bad++;
      $display("FAIL setup_lines got en_n=%0b sclk=%0b exp en_n=0 sclk=%0b", en_n, sclk, pl);
    end
  endtask

  task automatic finish_frame(input logic [7:0] h, input int l);
    int n, hh, exp_low, c;
    logic [7:0] e, g;
    n = (l > MAXD) ? MAXD : l;
    hh = (h == 0) ? 1 : int'(h);
    exp_low = hh * (16 * (n + 1) + 2);
    c = 0;
    while (en_n !== 1'b1 && c < 5000) begin
      step();
      c++;
    end
    total++;
    if (en_n !== 1'b1) begin
      bad++;
      $display("FAIL frame_timeout got en_n=%0b exp=1", en_n);
    end
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rsp_with_cs_rise got=%0b exp=1", rsp_valid);
    end
    total++;
    if (low_cnt != exp_low) begin
      bad++;
      $display("FAIL cs_low_cycles got=%0d exp=%0d", low_cnt, exp_low);
    end
    total++;
    if (mosi !== 1'b0 || sclk !== cur_cpol) begin
      bad++;
      $display("FAIL idle_lines got mosi=%0b sclk=%0b exp mosi=0 sclk=%0b", mosi, sclk, cur_cpol);
    end
    c = 0;
    while (cmd_ready !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    total++;
    if (c != GAPC) begin
      bad++;
      $display("FAIL gap_cycles got=%0d exp=%0d", c, GAPC);
    end
    total++;
    if (rsp_cnt != 1) begin
      bad++;
      $display("FAIL rsp_count got=%0d exp=1", rsp_cnt);
    end
    total++;
    if (rdata !== rdata_model) begin
      bad++;
      $display("FAIL rdata got=%08h exp=%08h", rdata, rdata_model);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++;
        $display("FAIL slave_byte got=none exp=%02h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL slave_byte got=%02h exp=%02h", g, e);
        end
      end
    end
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL slave_extra_bytes got=%0d exp=0", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) step();
    total++;
    if (en_n !== 1'b1) begin bad++; $display("FAIL reset_en_n got=%0b exp=1", en_n); end
    total++;
    if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%0b exp=0", sclk); end
    total++;
    if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%0b exp=0", mosi); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++;
    if (rsp_valid !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rsp got valid=%0b rdata=%08h exp 0 0", rsp_valid, rdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    expect_frame(CMD_CLUT, 1'b0, 1, 32'h15, 40'h0);
    start_frame(CMD_CLUT, 1'b0, 3'd1, 32'h15, 1'b0, 1'b0, 8'd3, 40'h0);
    finish_frame(8'd3, 1);
  endtask

  task automatic test_read();
    expect_frame(CMD_RD_CTRL, 1'b1, 4, 32'hDEADBEEF, 40'h00_11_22_33_44);
    start_frame(CMD_RD_CTRL, 1'b1, 3'd4, 32'hDEADBEEF, 1'b1, 1'b1, 8'd2, 40'h00_11_22_33_44);
    finish_frame(8'd2, 4);
    expect_frame(CMD_RD_CTRL, 1'b1, 1, 32'hFFFFFFFF, 40'h00_A5_5A_C3_3C);
    start_frame(CMD_RD_CTRL, 1'b1, 3'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 8'd3, 40'h00_A5_5A_C3_3C);
    finish_frame(8'd3, 1);
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++) begin
      expect_frame(8'h70, 1'b0, 2, 32'h3412, 40'h0);
      start_frame(8'h70, 1'b0, 3'd2, 32'h3412, m[1], m[0], 8'd2, 40'h0);
      finish_frame(8'd2, 2);
    end
  endtask

  task automatic test_abort();
    int c;
    start_frame(CMD_IMEM, 1'b1, 3'd4, 32'h0, 1'b1, 1'b0, 8'd2, 40'hFF_FFFF_FFFF);
    c = 0;
    while (sclk_edges < 10 && c < 500) begin
      step();
      c++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (en_n !== 1'b1 || sclk !== 1'b1 || mosi !== 1'b0) begin
      bad++;
      $display("FAIL abort_lines got en_n=%0b sclk=%0b mosi=%0b exp 1 1 0", en_n, sclk, mosi);
    end
    c = 0;
    while (cmd_ready !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    total++;
    if (rsp_cnt != 0) begin bad++; $display("FAIL abort_rsp got=%0d exp=0", rsp_cnt); end
    total++;
    if (rdata !== rdata_model) begin
      bad++;
      $display("FAIL abort_rdata got=%08h exp=%08h", rdata, rdata_model);
    end
    got_q.delete();
    exp_q.delete();
    expect_frame(CMD_SCHG_LO, 1'b0, 2, 32'hBEEF, 40'h0);
    start_frame(CMD_SCHG_LO, 1'b0, 3'd2, 32'hBEEF, 1'b0, 1'b1, 8'd1, 40'h0);
    finish_frame(8'd1, 2);
  endtask

  task automatic test_boundaries();
    expect_frame(CMD_CTRL, 1'b0, 0, 32'h0, 40'h0);
    start_frame(CMD_CTRL, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 8'd0, 40'h0);
    finish_frame(8'd0, 0);
    expect_frame(CMD_CLKEN, 1'b0, 0, 32'h0, 40'h0);
    start_frame(CMD_CLKEN, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 8'd1, 40'h0);
    finish_frame(8'd1, 0);
    expect_frame(CMD_CLKEN, 1'b0, 0, 32'h0, 40'h0);
    start_frame(CMD_CLKEN, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 8'd3, 40'h0);
    finish_frame(8'd3, 0);
    expect_frame(CMD_SCHG_HI, 1'b0, 7, 32'h44332211, 40'h0);
    start_frame(CMD_SCHG_HI, 1'b0, 3'd7, 32'h44332211, 1'b0, 1'b0, 8'd1, 40'h0);
    finish_frame(8'd1, 7);
  endtask

  task automatic test_reset_mid_frame();
    int c;
    start_frame(CMD_CLUT, 1'b1, 3'd2, 32'h0, 1'b1, 1'b0, 8'd2, 40'h00_77_66_00_00);
    c = 0;
    while (sclk_edges < 6 && c < 500) begin
      step();
      c++;
    end
    rst_n = 1'b0;
    step();
    total++;
    if (en_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
      bad++;
      $display("FAIL midrst_lines got en_n=%0b sclk=%0b mosi=%0b exp 1 0 0", en_n, sclk, mosi);
    end
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_status got ready=%0b busy=%0b rsp=%0b exp 1 0 0", cmd_ready, busy, rsp_valid);
    end
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%08h exp=0", rdata); end
    rst_n = 1'b1;
    rdata_model = '0;
    got_q.delete();
    exp_q.delete();
    step();
    expect_frame(CMD_CTRL, 1'b0, 1, 32'hC3, 40'h0);
    start_frame(CMD_CTRL, 1'b0, 3'd1, 32'hC3, 1'b0, 1'b0, 8'd1, 40'h0);
    finish_frame(8'd1, 1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_modes();
    test_abort();
    test_boundaries();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
